// File: rtl/line_table_sched_if.sv
// Write and read stream bundle for line_table_sched.
// slave = table side, master = pipeline/consumer side.
interface line_table_sched_if #(
    parameter int IDX_W = 3
);
    logic             wr_valid_in;
    logic             wr_ready_out;
    logic [41:0]      wr_line_in;
    logic             wr_last_in;
    logic             out_valid_out;
    logic             out_ready_in;
    logic [41:0]      out_line_out;
    logic [IDX_W-1:0] out_idx_out;
    logic             out_last_out;

    modport master (
        output wr_valid_in, wr_line_in, wr_last_in, out_ready_in,
        input  wr_ready_out, out_valid_out, out_line_out,
        input  out_idx_out, out_last_out
    );

    modport slave (
        input  wr_valid_in, wr_line_in, wr_last_in, out_ready_in,
        output wr_ready_out, out_valid_out, out_line_out,
        output out_idx_out, out_last_out
    );
endinterface

// File: rtl/line_table_sched.sv
// Double-banked line segment table: batches fill the shadow bank,
// frame_start commits it and streams the active bank. Option: LINE_NORMALIZE_EN.
module line_table_sched #(
    parameter int MAX_LINES = 8,
    parameter int IDX_W     = $clog2(MAX_LINES),
    parameter int CNT_W     = $clog2(MAX_LINES) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_start_in,
    line_table_sched_if.slave bus,
    output logic             frame_done_out,
    output logic [CNT_W-1:0] active_count_out,
    output logic             overflow_out,
    output logic             overrun_out
);
    typedef enum logic [1:0] {
        S_IDLE, S_COMMIT, S_STREAM, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_bank_sel;
    logic             r_pending;
    logic             r_overflow;
    logic             r_overrun;
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_active_cnt;
    logic [IDX_W-1:0] r_rd_idx;
    logic [41:0]      r_mem [2*MAX_LINES];

    logic             w_wr_ready;
    logic             w_wr_acc;
    logic             w_wr_store;
    logic             w_out_valid;
    logic             w_out_acc;
    logic             w_last;
    logic             w_empty;
    logic             w_commit;
    logic [41:0]      w_wr_line;

`ifdef LINE_NORMALIZE_EN
    // Orders endpoints so x1<=x2, breaking x ties on y.
    function automatic logic [41:0] norm(input logic [41:0] l);
        logic [10:0] x1, x2;
        logic [9:0]  y1, y2;
        {x1, y1, x2, y2} = l;
        if (x1 > x2 || (x1 == x2 && y1 > y2))
            norm = {x2, y2, x1, y1};
        else
            norm = l;
    endfunction
    assign w_wr_line = norm(bus.wr_line_in);
`else
    assign w_wr_line = bus.wr_line_in;
`endif

    // Ready is held low while in reset, independent of register state.
    assign w_wr_ready = rst_in && !r_pending;
    assign w_wr_acc   = bus.wr_valid_in && w_wr_ready;
    assign w_wr_store = w_wr_acc && (r_wr_ptr < CNT_W'(MAX_LINES));
    assign w_empty    = (r_active_cnt == '0);
    assign w_last     = ({1'b0, r_rd_idx} == r_active_cnt - CNT_W'(1));
    assign w_out_acc  = w_out_valid && bus.out_ready_in;

    assign bus.wr_ready_out  = w_wr_ready;
    assign bus.out_valid_out = w_out_valid;
    assign bus.out_idx_out   = w_out_valid ? r_rd_idx : '0;
    assign bus.out_last_out  = w_out_valid && w_last;
    assign bus.out_line_out  = w_out_valid ? r_mem[{r_bank_sel, r_rd_idx}] : '0;
    assign active_count_out  = r_active_cnt;
    assign overflow_out      = r_overflow;
    assign overrun_out       = r_overrun;

    // Frame sequencing state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state plus per-state strobes.
    always_comb begin
        w_next         = r_state;
        w_out_valid    = 1'b0;
        frame_done_out = 1'b0;
        w_commit       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (frame_start_in)
                    w_next = r_pending ? S_COMMIT : S_STREAM;
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                w_next   = S_STREAM;
            end
            S_STREAM: begin
                if (w_empty) begin
                    w_next = S_DONE;
                end else begin
                    w_out_valid = 1'b1;
                    if (bus.out_ready_in && w_last)
                        w_next = S_DONE;
                end
            end
            S_DONE: begin
                frame_done_out = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Batch bookkeeping and bank swap at commit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bank_sel   <= 1'b0;
            r_pending    <= 1'b0;
            r_overflow   <= 1'b0;
            r_wr_ptr     <= '0;
            r_active_cnt <= '0;
        end else if (w_commit) begin
            r_bank_sel   <= ~r_bank_sel;
            r_active_cnt <= r_wr_ptr;
            r_wr_ptr     <= '0;
            r_pending    <= 1'b0;
        end else if (w_wr_acc) begin
            if (w_wr_store) r_wr_ptr   <= r_wr_ptr + CNT_W'(1);
            else            r_overflow <= 1'b1;
            if (bus.wr_last_in) r_pending <= 1'b1;
        end
    end

    // Read index walks the active bank during a stream.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                    r_rd_idx <= '0;
        else if (r_state != S_STREAM)   r_rd_idx <= '0;
        else if (w_out_acc && !w_last)  r_rd_idx <= r_rd_idx + IDX_W'(1);
    end

    // Frame start outside IDLE is recorded but otherwise ignored.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            r_overrun <= 1'b0;
        else if (frame_start_in && r_state != S_IDLE)
            r_overrun <= 1'b1;
    end

    // Segment storage; writes always target the shadow bank.
    always_ff @(posedge clk_in) begin
        if (w_wr_store)
            r_mem[{~r_bank_sel, r_wr_ptr[IDX_W-1:0]}] <= w_wr_line;
    end
endmodule

// File: tb/tb_line_table_sched.sv
// Directed bench for line_table_sched: batch table plus
// stall, overrun, empty-frame and normalisation sequences.
module tb_line_table_sched;
    localparam int ML = 8;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       frame_start_in = 1'b0;
    logic       frame_done_out;
    logic [3:0] active_count_out;
    logic       overflow_out;
    logic       overrun_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [41:0] wr_q[$];
    logic [41:0] exp_q[$];

    line_table_sched_if #(.IDX_W(3)) bus ();

    line_table_sched #(.MAX_LINES(ML)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .frame_start_in   (frame_start_in),
        .bus              (bus),
        .frame_done_out   (frame_done_out),
        .active_count_out (active_count_out),
        .overflow_out     (overflow_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int n;
        int base;
        int exp_cnt;
        bit exp_ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [41:0] mk(input int b, input int i);
        logic [10:0] x1, x2;
        logic [9:0]  y1, y2;
        x1 = 11'(b * 10 + i);
        y1 = 10'(b * 3 + i * 7);
        x2 = 11'(1024 + b * 10 + i);
        y2 = 10'(500 + i);
        return {x1, y1, x2, y2};
    endfunction

    // Writes every line of wr_q, last flag on the final one.
    task automatic write_lines();
        int w;
        for (int i = 0; i < wr_q.size(); i++) begin
            bus.wr_valid_in = 1'b1;
            bus.wr_line_in  = wr_q[i];
            bus.wr_last_in  = (i == wr_q.size() - 1);
            w = 0;
            while (!bus.wr_ready_out && w < 50) begin
                tick();
                w++;
            end
            chk("wr_ready", {63'd0, bus.wr_ready_out}, 64'd1);
            tick();
        end
        bus.wr_valid_in = 1'b0;
        bus.wr_last_in  = 1'b0;
    endtask

    // Pulses frame_start and checks the stream against exp_q.
    task automatic run_frame(input int exp_first, input int exp_done,
                             input bit stall);
        int cyc, k, first, done;
        k     = 0;
        first = -1;
        done  = -1;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        cyc = 1;
        while (done < 0 && cyc < 100) begin
            bus.out_ready_in = stall ? (cyc % 2 == 0) : 1'b1;
            if (frame_done_out) done = cyc;
            if (bus.out_valid_out) begin
                if (first < 0) first = cyc;
                chk("idx", {61'd0, bus.out_idx_out}, 64'(k));
                if (k < exp_q.size())
                    chk("line", {22'd0, bus.out_line_out}, {22'd0, exp_q[k]});
                chk("last", {63'd0, bus.out_last_out},
                    64'(k == exp_q.size() - 1));
                if (bus.out_ready_in) k++;
            end
            tick();
            cyc++;
        end
        bus.out_ready_in = 1'b0;
        chk("beats", 64'(k), 64'(exp_q.size()));
        chk("done_seen", 64'(done >= 0), 64'd1);
        if (exp_first >= 0) chk("first_lat", 64'(first), 64'(exp_first));
        if (exp_done >= 0)  chk("done_lat", 64'(done), 64'(exp_done));
    endtask

    initial begin
        vec_t vecs[4];
        logic [41:0] raw, nrm;

        vecs[0] = '{n: 3,  base: 1,  exp_cnt: 3, exp_ovf: 1'b0};
        vecs[1] = '{n: 1,  base: 5,  exp_cnt: 1, exp_ovf: 1'b0};
        vecs[2] = '{n: 8,  base: 9,  exp_cnt: 8, exp_ovf: 1'b0};
        vecs[3] = '{n: 10, base: 20, exp_cnt: 8, exp_ovf: 1'b1};

        bus.wr_valid_in  = 1'b0;
        bus.wr_line_in   = '0;
        bus.wr_last_in   = 1'b0;
        bus.out_ready_in = 1'b0;

        tick();
        tick();
        chk("rst_wr_ready", {63'd0, bus.wr_ready_out}, 64'd0);
        chk("rst_valid", {63'd0, bus.out_valid_out}, 64'd0);
        chk("rst_done", {63'd0, frame_done_out}, 64'd0);
        chk("rst_count", {60'd0, active_count_out}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_out}, 64'd0);
        chk("rst_ovr", {63'd0, overrun_out}, 64'd0);
        rst_in = 1'b1;
        #1;
        chk("post_rst_ready", {63'd0, bus.wr_ready_out}, 64'd1);
        tick();

        // Empty table: no beats, done two cycles after the pulse.
        exp_q.delete();
        run_frame(-1, 2, 1'b0);
        tick();

        for (int v = 0; v < 4; v++) begin
            wr_q.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].n; i++) wr_q.push_back(mk(vecs[v].base, i));
            for (int i = 0; i < vecs[v].exp_cnt; i++) exp_q.push_back(mk(vecs[v].base, i));
            write_lines();
            chk("pending_ready", {63'd0, bus.wr_ready_out}, 64'd0);
            run_frame(2, 2 + vecs[v].exp_cnt, 1'b0);
            chk("count", {60'd0, active_count_out}, 64'(vecs[v].exp_cnt));
            chk("ovf", {63'd0, overflow_out}, 64'(vecs[v].exp_ovf));
            tick();
        end

        // Fresh 3-line batch, then replay it with a stalling consumer.
        wr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) wr_q.push_back(mk(30, i));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(30, i));
        write_lines();
        run_frame(2, 5, 1'b0);
        tick();
        run_frame(1, -1, 1'b1);
        tick();
        chk("ovr_clear", {63'd0, overrun_out}, 64'd0);

        // Replay old batch while a new batch and a stray pulse arrive.
        fork
            run_frame(1, 4, 1'b0);
            begin
                tick();
                tick();
                frame_start_in  = 1'b1;
                bus.wr_valid_in = 1'b1;
                bus.wr_line_in  = mk(40, 0);
                bus.wr_last_in  = 1'b0;
                chk("mid_ready", {63'd0, bus.wr_ready_out}, 64'd1);
                tick();
                frame_start_in  = 1'b0;
                bus.wr_line_in  = mk(40, 1);
                bus.wr_last_in  = 1'b1;
                tick();
                bus.wr_valid_in = 1'b0;
                bus.wr_last_in  = 1'b0;
            end
        join
        chk("overrun", {63'd0, overrun_out}, 64'd1);
        chk("old_count", {60'd0, active_count_out}, 64'd3);
        tick();
        exp_q.delete();
        exp_q.push_back(mk(40, 0));
        exp_q.push_back(mk(40, 1));
        run_frame(2, 4, 1'b0);
        chk("new_count", {60'd0, active_count_out}, 64'd2);
        tick();

        // Reversed segment: swapped only when normalisation is built in.
        raw = {11'd500, 10'd40, 11'd100, 10'd300};
        nrm = {11'd100, 10'd300, 11'd500, 10'd40};
        wr_q.delete();
        wr_q.push_back(raw);
        exp_q.delete();
`ifdef LINE_NORMALIZE_EN
        exp_q.push_back(nrm);
`else
        exp_q.push_back(raw);
        if (nrm == raw) $display("note: unexpected equal vectors");
`endif
        write_lines();
        run_frame(2, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/line_table_sched.md
Name: line_table_sched

Overview:
- Owns the table of crayon line segments shown on screen.
- Accepts segment batches from the detection pipeline over a valid/ready stream into a shadow bank.
- Commits the shadow bank to the active bank only at a frame boundary, so a frame never mixes two batches.
- Once per frame, streams the active segments in index order to the line-rendering and physics consumers, one segment per accepted beat.

Parameters:
- MAX_LINES, 8: table depth per bank; must be a power of two, at least 2.
- IDX_W, $clog2(MAX_LINES): width of segment index outputs.
- CNT_W, $clog2(MAX_LINES)+1: width of count outputs.

Ports:
- clk_in  input  1  system/pixel clock
- rst_in  input  1  asynchronous, active-low reset
- frame_start_in  input  1  one-cycle pulse at hcount=0, vcount=0
- wr_valid_in  input  1  write beat valid
- wr_ready_out  output  1  write beat accepted when high with wr_valid_in
- wr_line_in  input  42  {x1[10:0], y1[9:0], x2[10:0], y2[9:0]}
- wr_last_in  input  1  beat closes the current batch
- out_valid_out  output  1  streamed segment valid
- out_ready_in  input  1  consumer accepts segment
- out_line_out  output  42  segment, same packing as wr_line_in
- out_idx_out  output  IDX_W  index of streamed segment
- out_last_out  output  1  final segment of this frame
- frame_done_out  output  1  one-cycle pulse when the frame's stream completes
- active_count_out  output  CNT_W  segments in active bank
- overflow_out  output  1  sticky: batch exceeded MAX_LINES
- overrun_out  output  1  sticky: frame_start arrived while streaming

Behaviour:
- Reset (rst_in low, async):
  - FSM to IDLE; bank_sel=0.
  - Write pointer, pending flag and both counts cleared.
  - All outputs 0, except wr_ready_out=0 during reset and 1 in the first cycle after reset.
- Write side:
  - A beat is accepted when wr_valid_in && wr_ready_out.
  - wr_ready_out = !pending.
  - Accepted beat with wr_ptr<MAX_LINES: stored at shadow[wr_ptr]; wr_ptr increments.
  - Accepted beat with wr_ptr==MAX_LINES: dropped, overflow_out set; wr_ptr saturates.
  - An accepted beat with wr_last_in sets pending=1, so wr_ready_out drops the next cycle.
- FSM states:
  - IDLE:
    - On frame_start_in with pending: go to COMMIT.
    - On frame_start_in without pending: go to STREAM, replaying the existing active bank.
  - COMMIT (1 cycle):
    - Toggle bank_sel; active_count = wr_ptr.
    - Clear wr_ptr and pending.
    - Go to STREAM.
  - STREAM:
    - Maintain rd_idx from 0.
    - out_valid_out=1 with out_line_out=active[rd_idx], out_idx_out=rd_idx, out_last_out=(rd_idx==active_count-1).
    - Outputs hold stable while out_ready_in is low.
    - On an accepted beat with out_last_out: go to DONE. Otherwise rd_idx increments.
    - If active_count==0: no beats are issued; go directly to DONE.
  - DONE (1 cycle): frame_done_out=1; go to IDLE.
- Latency:
  - First out_valid_out is 1 cycle after frame_start_in without a commit, and 2 cycles after it with a commit.
  - Back-to-back beats are sustained while out_ready_in is held high.
- Simultaneous events:
  - A write beat in the COMMIT cycle is impossible, because pending forces wr_ready_out low.
  - Writes during STREAM land only in the shadow bank and never affect the stream in flight.
  - frame_start_in in STREAM, COMMIT or DONE: ignored, and overrun_out set. The stream finishes normally.
  - wr_last_in on the beat that overflows: closes the batch, active_count = MAX_LINES.
- Reset mid-stream aborts immediately; no frame_done_out is issued.

Optional Feature:
- Macro: LINE_NORMALIZE_EN.
- When defined: each accepted write is stored with endpoints swapped when x1>x2, so stored x1<=x2 and y follows its x. When x1==x2 and y1>y2, the endpoints are also swapped.
- When undefined: segments are stored exactly as written.

Test Plan:
- Reset, write 3 beats (last on 3rd), pulse frame_start, out_ready_in=1 -> idx 0,1,2 on consecutive cycles, out_last_out on idx 2, frame_done_out 1 cycle later, active_count_out=3.
- 10 beats with MAX_LINES=8 -> beats 9-10 dropped, overflow_out=1, stream yields 8 segments.
- Stream the 3-line batch with out_ready_in toggled 1/0 -> each segment held stable while stalled, no index skipped or repeated.
- Write a new 2-line batch during a stream, then frame_start -> current frame streams the old 3 lines, next frame streams the new 2; second frame_start mid-stream sets overrun_out.
- Frame_start with empty table after reset -> no out_valid_out, frame_done_out 2 cycles after the pulse.
- With LINE_NORMALIZE_EN, write {x1=500,y1=40,x2=100,y2=300} -> streamed as {100,300,500,40}; without the macro it streams unchanged.
